// File: rtl/dec_sel_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoder: registered select/enable plus one-hot grant.
// Grants are bounded by MAX_HOLD cycles and always separated by one dead (GAP) cycle.
module dec_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] gnt,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic       en_q, en_d;
    logic [3:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic [1:0] winner;
    logic       exit_done, exit_wd, exit_max;

    // Scan last+4 down to last+1 so the nearest requester after last wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        pick = last;
        for (int unsigned k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        winner    = pick(req, last_q);
        exit_done = done;
        exit_wd   = !req[sel_q];
        exit_max  = (cnt_q == 8'(MAX_HOLD));

        state_d   = state_q;
        sel_d     = sel_q;
        en_d      = en_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;

        case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    en_d    = 1'b1;
                    gnt_d   = 4'b0001 << winner;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                if (exit_done || exit_wd || exit_max) begin
                    state_d   = GAP;
                    en_d      = 1'b0;
                    gnt_d     = '0;
                    last_d    = sel_q;
                    cnt_d     = '0;
                    timeout_d = exit_max && !exit_done && !exit_wd;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            en_q      <= 1'b0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign sel     = sel_q;
    assign en      = en_q;
    assign gnt     = gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_dec_sel_arbiter.sv
// Directed bench for dec_sel_arbiter: one instance with MAX_HOLD=8, one with MAX_HOLD=1.
// Outputs are compared packed as {sel, en, gnt, timeout}.
module tb_dec_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst8, done8, rst1, done1;
    logic [3:0] req8, req1;
    logic [1:0] sel8, sel1;
    logic       en8, en1, to8, to1;
    logic [3:0] gnt8, gnt1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    dec_sel_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst8), .req(req8), .done(done8),
        .sel(sel8), .en(en8), .gnt(gnt8), .timeout(to8)
    );

    dec_sel_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst1), .req(req1), .done(done1),
        .sel(sel1), .en(en1), .gnt(gnt1), .timeout(to1)
    );

    wire [7:0] o8 = {sel8, en8, gnt8, to8};
    wire [7:0] o1 = {sel1, en1, gnt1, to1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got sel/en/gnt/to=%b required %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst8 = 1'b1; req8 = 4'b0000; done8 = 1'b0;
        rst1 = 1'b1; req1 = 4'b0000; done1 = 1'b0;
        step();
        chk("reset8", o8, {2'b00, 1'b0, 4'b0000, 1'b0});
        chk("reset1", o1, {2'b00, 1'b0, 4'b0000, 1'b0});
        rst8 = 1'b0;
        step();
        chk("idle_noreq", o8, {2'b00, 1'b0, 4'b0000, 1'b0});

        // 1: single requester, done in third grant cycle
        req8 = 4'b0001;
        step(); chk("t1_g1", o8, {2'b00, 1'b1, 4'b0001, 1'b0});
        step(); chk("t1_g2", o8, {2'b00, 1'b1, 4'b0001, 1'b0});
        step(); chk("t1_g3", o8, {2'b00, 1'b1, 4'b0001, 1'b0});
        done8 = 1'b1;
        step(); chk("t1_gap", o8, {2'b00, 1'b0, 4'b0000, 1'b0});
        done8 = 1'b0;
        step(); chk("t1_regrant", o8, {2'b00, 1'b1, 4'b0001, 1'b0});
        req8 = 4'b0000;
        step(); chk("t1_withdraw_gap", o8, {2'b00, 1'b0, 4'b0000, 1'b0});
        step(); chk("t1_idle", o8, {2'b00, 1'b0, 4'b0000, 1'b0});

        // 2: all requesting, full-length grants rotate 0,1,2,3,0
        rst8 = 1'b1; req8 = 4'b1111;
        step(); chk("t2_reset", o8, {2'b00, 1'b0, 4'b0000, 1'b0});
        rst8 = 1'b0;
        step();
        for (int g = 0; g < 5; g++) begin
            logic [1:0] w;
            logic [3:0] oh;
            w  = 2'(g % 4);
            oh = (g % 4 == 0) ? 4'b0001 : (g % 4 == 1) ? 4'b0010 :
                 (g % 4 == 2) ? 4'b0100 : 4'b1000;
            for (int c = 1; c <= 8; c++) begin
                chk($sformatf("t2_g%0d_c%0d", g, c), o8, {w, 1'b1, oh, 1'b0});
                step();
            end
            chk($sformatf("t2_gap%0d", g), o8, {w, 1'b0, 4'b0000, 1'b1});
            step();
        end

        // 3: grant to 1 ends, req=1010 -> 3 then 1
        chk("t3_g1", o8, {2'b01, 1'b1, 4'b0010, 1'b0});
        req8 = 4'b1010; done8 = 1'b1;
        step(); chk("t3_gap1", o8, {2'b01, 1'b0, 4'b0000, 1'b0});
        step(); chk("t3_g3", o8, {2'b11, 1'b1, 4'b1000, 1'b0});
        step(); chk("t3_gap3", o8, {2'b11, 1'b0, 4'b0000, 1'b0});
        done8 = 1'b0;
        step(); chk("t3_g1b", o8, {2'b01, 1'b1, 4'b0010, 1'b0});

        // 4: done coincides with counter==MAX_HOLD
        for (int c = 2; c <= 8; c++) begin
            step(); chk($sformatf("t4_c%0d", c), o8, {2'b01, 1'b1, 4'b0010, 1'b0});
        end
        done8 = 1'b1;
        step(); chk("t4_gap_no_to", o8, {2'b01, 1'b0, 4'b0000, 1'b0});
        step(); chk("t4_done_in_gap_ignored", o8, {2'b11, 1'b1, 4'b1000, 1'b0});
        done8 = 1'b0;

        // 5: reset in the middle of a grant to 2
        req8 = 4'b0100;
        step(); chk("t5_wd_gap", o8, {2'b11, 1'b0, 4'b0000, 1'b0});
        step(); chk("t5_g2", o8, {2'b10, 1'b1, 4'b0100, 1'b0});
        step(); chk("t5_g2c2", o8, {2'b10, 1'b1, 4'b0100, 1'b0});
        rst8 = 1'b1; req8 = 4'b1111;
        step(); chk("t5_reset", o8, {2'b00, 1'b0, 4'b0000, 1'b0});
        rst8 = 1'b0;
        step(); chk("t5_g0", o8, {2'b00, 1'b1, 4'b0001, 1'b0});

        // 6: MAX_HOLD=1, requesters 1 and 2 alternate
        rst1 = 1'b0; req1 = 4'b0110;
        for (int g = 0; g < 4; g++) begin
            logic [1:0] w;
            logic [3:0] oh;
            w  = (g % 2 == 0) ? 2'b01 : 2'b10;
            oh = (g % 2 == 0) ? 4'b0010 : 4'b0100;
            step(); chk($sformatf("t6_g%0d", g), o1, {w, 1'b1, oh, 1'b0});
            step(); chk($sformatf("t6_gap%0d", g), o1, {w, 1'b0, 4'b0000, 1'b1});
        end
        step(); chk("t6_g1_done", o1, {2'b01, 1'b1, 4'b0010, 1'b0});
        done1 = 1'b1;
        step(); chk("t6_gap_done", o1, {2'b01, 1'b0, 4'b0000, 1'b0});
        done1 = 1'b0; req1 = 4'b0000;
        step(); chk("t6_idle", o1, {2'b01, 1'b0, 4'b0000, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
